// File: rtl/led_sched_pkg.sv
// Shared types and elaboration-time helpers for the LED blink scheduler.
package led_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_e;

    // Width needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int calc_presc_w(input int clk_hz, input int tick_hz);
        return clog2(calc_div(clk_hz, tick_hz));
    endfunction

endpackage

// File: rtl/led_blink_scheduler_tick_gen.sv
// Timebase prescaler: counts 0..DIV-1 and pulses tick on the last count.
module tick_gen
    import led_sched_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_blink_scheduler.sv
// Round-robin arbiter that lends the single status LED to one requester at a
// time and plays its k-pulse blink pattern with fixed on/off/gap timing.
module led_blink_scheduler
    import led_sched_pkg::*;
#(
    parameter int CLK_HZ    = 25_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int N_REQ     = 4,
    parameter int CNT_W     = 4,
    parameter int ON_TICKS  = 200,
    parameter int OFF_TICKS = 200,
    parameter int GAP_TICKS = 600
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] blinks,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   led
);

    localparam int DIV       = calc_div(CLK_HZ, TICK_HZ);
    localparam int IDX_W     = clog2(N_REQ);
    localparam int MAX_OO    = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAX_TICKS = (MAX_OO > GAP_TICKS) ? MAX_OO : GAP_TICKS;
    localparam int TCNT_W    = clog2(MAX_TICKS);

    localparam logic [TCNT_W-1:0] ON_LAST  = TCNT_W'(ON_TICKS - 1);
    localparam logic [TCNT_W-1:0] OFF_LAST = TCNT_W'(OFF_TICKS - 1);
    localparam logic [TCNT_W-1:0] GAP_LAST = TCNT_W'(GAP_TICKS - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(N_REQ - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, busy_d;
    logic               led_q, led_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic [TCNT_W-1:0]  phase_last;
    logic               tick;
    logic               clr;
    logic               phase_end;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [CNT_W-1:0]   blinks_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign blinks_arr[gi] = blinks[gi*CNT_W +: CNT_W];
    end

    // Scan starting just after the previous owner so it gets lowest priority.
    always_comb begin : arb
        logic [IDX_W-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = rr_q;
        for (int off = 0; off < N_REQ; off++) begin
            idx = (idx == IDX_MAX) ? '0 : idx + 1'b1;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        case (state_q)
            ON:      phase_last = ON_LAST;
            OFF:     phase_last = OFF_LAST;
            default: phase_last = GAP_LAST;
        endcase
    end

    assign phase_end = tick && (tcnt_q == phase_last);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        done_d  = '0;
        led_d   = led_q;
        case (state_q)
            IDLE: begin
                // A pending done pulse means this is the completion cycle:
                // release the grant, arbitrate only on the following cycle.
                if (done_q != '0) begin
                    grant_d = '0;
                end else if (win_found) begin
                    rr_d             = win_idx;
                    rem_d            = blinks_arr[win_idx];
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    if (blinks_arr[win_idx] != '0) begin
                        state_d = ON;
                        led_d   = 1'b1;
                    end else begin
                        state_d         = GAP;
                        done_d          = '0;
                        done_d[win_idx] = 1'b1;
                    end
                end
            end
            ON: begin
                if (phase_end) begin
                    rem_d   = rem_q - 1'b1;
                    led_d   = 1'b0;
                    state_d = (rem_q == CNT_W'(1)) ? GAP : OFF;
                end
            end
            OFF: begin
                if (phase_end) begin
                    state_d = ON;
                    led_d   = 1'b1;
                end
            end
            GAP: begin
                // Zero-count grants pass through GAP for their single done cycle.
                if (done_q != '0) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (phase_end) begin
                    state_d = IDLE;
                    done_d  = grant_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Restart the timebase on every transition so phases are cycle-exact.
    assign clr = (state_d != state_q) || (state_q == IDLE);

    always_comb begin
        tcnt_d = tcnt_q;
        if (clr) begin
            tcnt_d = '0;
        end else if (tick) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            rr_q    <= IDX_MAX;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            led_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
            tcnt_q  <= tcnt_d;
        end
    end

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign led   = led_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with DIV=10, ON=2, OFF=1, GAP=3 ticks.
module tb_led_blink_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] blinks;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic        led;

    int checks;
    int errors;

    typedef struct {
        int          scen;
        int          cyc;
        logic        rst;
        logic [3:0]  req;
        logic [15:0] blinks;
        logic [3:0]  grant;
        logic [3:0]  done;
        logic        busy;
        logic        led;
    } vec_t;

    vec_t vecs[$];

    led_blink_scheduler #(
        .CLK_HZ    (1000),
        .TICK_HZ   (100),
        .N_REQ     (4),
        .CNT_W     (4),
        .ON_TICKS  (2),
        .OFF_TICKS (1),
        .GAP_TICKS (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .blinks (blinks),
        .grant  (grant),
        .done   (done),
        .busy   (busy),
        .led    (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    function automatic vec_t mk(input int scen, input int cyc, input logic r,
                                input logic [3:0] rq, input logic [15:0] bl,
                                input logic [3:0] g, input logic [3:0] d,
                                input logic b, input logic l);
        vec_t v;
        v.scen = scen; v.cyc = cyc; v.rst = r; v.req = rq; v.blinks = bl;
        v.grant = g; v.done = d; v.busy = b; v.led = l;
        return v;
    endfunction

    // Leaves the bench at a falling edge just after one reset edge: cycle 0.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        blinks = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cur_scen;
        int cur_cyc;
        int exp_v;
        int act_v;
        int cyc;
        int led_hi;
        int rises;
        int done_cyc;
        int done_cnt;
        logic prev_led;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        req = '0;
        blinks = '0;

        // scenario 1: single pattern, requester 1, two pulses
        vecs.push_back(mk(1,   0, 0, 4'b0010, 16'h0020, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(1,   1, 0, 4'b0010, 16'h0020, 4'b0010, 4'b0000, 1, 1));
        vecs.push_back(mk(1,  20, 0, 4'b0010, 16'h0020, 4'b0010, 4'b0000, 1, 1));
        vecs.push_back(mk(1,  21, 0, 4'b0010, 16'h0020, 4'b0010, 4'b0000, 1, 0));
        vecs.push_back(mk(1,  30, 0, 4'b0010, 16'h0020, 4'b0010, 4'b0000, 1, 0));
        vecs.push_back(mk(1,  31, 0, 4'b0010, 16'h0020, 4'b0010, 4'b0000, 1, 1));
        vecs.push_back(mk(1,  50, 0, 4'b0010, 16'h0020, 4'b0010, 4'b0000, 1, 1));
        vecs.push_back(mk(1,  51, 0, 4'b0010, 16'h0020, 4'b0010, 4'b0000, 1, 0));
        vecs.push_back(mk(1,  80, 0, 4'b0010, 16'h0020, 4'b0010, 4'b0000, 1, 0));
        vecs.push_back(mk(1,  81, 0, 4'b0000, 16'h0020, 4'b0010, 4'b0010, 0, 0));
        vecs.push_back(mk(1,  82, 0, 4'b0000, 16'h0020, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(1,  84, 0, 4'b0000, 16'h0020, 4'b0000, 4'b0000, 0, 0));
        // scenario 2: all requesting, one pulse each, 52-cycle rotation
        vecs.push_back(mk(2,   0, 0, 4'b1111, 16'h1111, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(2,   1, 0, 4'b1111, 16'h1111, 4'b0001, 4'b0000, 1, 1));
        vecs.push_back(mk(2,  21, 0, 4'b1111, 16'h1111, 4'b0001, 4'b0000, 1, 0));
        vecs.push_back(mk(2,  51, 0, 4'b1111, 16'h1111, 4'b0001, 4'b0001, 0, 0));
        vecs.push_back(mk(2,  52, 0, 4'b1111, 16'h1111, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(2,  53, 0, 4'b1111, 16'h1111, 4'b0010, 4'b0000, 1, 1));
        vecs.push_back(mk(2, 103, 0, 4'b1111, 16'h1111, 4'b0010, 4'b0010, 0, 0));
        vecs.push_back(mk(2, 105, 0, 4'b1111, 16'h1111, 4'b0100, 4'b0000, 1, 1));
        vecs.push_back(mk(2, 155, 0, 4'b1111, 16'h1111, 4'b0100, 4'b0100, 0, 0));
        vecs.push_back(mk(2, 157, 0, 4'b1111, 16'h1111, 4'b1000, 4'b0000, 1, 1));
        vecs.push_back(mk(2, 207, 0, 4'b1111, 16'h1111, 4'b1000, 4'b1000, 0, 0));
        vecs.push_back(mk(2, 209, 0, 4'b1111, 16'h1111, 4'b0001, 4'b0000, 1, 1));
        // scenario 3: zero-count request
        vecs.push_back(mk(3,   0, 0, 4'b0100, 16'h0000, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(3,   1, 0, 4'b0000, 16'h0000, 4'b0100, 4'b0100, 1, 0));
        vecs.push_back(mk(3,   2, 0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(3,   3, 0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 0));
        // scenario 4: req/blinks change after grant are ignored
        vecs.push_back(mk(4,   0, 0, 4'b0001, 16'h0003, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(4,   1, 0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1, 1));
        vecs.push_back(mk(4,   5, 0, 4'b0000, 16'h0007, 4'b0001, 4'b0000, 1, 1));
        vecs.push_back(mk(4,  61, 0, 4'b0000, 16'h0007, 4'b0001, 4'b0000, 1, 1));
        vecs.push_back(mk(4,  80, 0, 4'b0000, 16'h0007, 4'b0001, 4'b0000, 1, 1));
        vecs.push_back(mk(4,  81, 0, 4'b0000, 16'h0007, 4'b0001, 4'b0000, 1, 0));
        vecs.push_back(mk(4, 110, 0, 4'b0000, 16'h0007, 4'b0001, 4'b0000, 1, 0));
        vecs.push_back(mk(4, 111, 0, 4'b0000, 16'h0007, 4'b0001, 4'b0001, 0, 0));
        vecs.push_back(mk(4, 112, 0, 4'b0000, 16'h0007, 4'b0000, 4'b0000, 0, 0));
        // scenario 5: reset during OFF, then requester 0 wins over 3
        vecs.push_back(mk(5,   0, 0, 4'b0010, 16'h0020, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(5,  25, 1, 4'b0010, 16'h0020, 4'b0010, 4'b0000, 1, 0));
        vecs.push_back(mk(5,  26, 0, 4'b1001, 16'h1001, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(5,  27, 0, 4'b1001, 16'h1001, 4'b0001, 4'b0000, 1, 1));
        vecs.push_back(mk(5,  46, 0, 4'b1001, 16'h1001, 4'b0001, 4'b0000, 1, 1));
        vecs.push_back(mk(5,  47, 0, 4'b1001, 16'h1001, 4'b0001, 4'b0000, 1, 0));
        // scenario 6: requester 3 withdraws before the owner finishes
        vecs.push_back(mk(6,   0, 0, 4'b0001, 16'h0001, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(6,   1, 0, 4'b0001, 16'h0001, 4'b0001, 4'b0000, 1, 1));
        vecs.push_back(mk(6,  10, 0, 4'b1001, 16'h0001, 4'b0001, 4'b0000, 1, 1));
        vecs.push_back(mk(6,  20, 0, 4'b0001, 16'h0001, 4'b0001, 4'b0000, 1, 1));
        vecs.push_back(mk(6,  51, 0, 4'b0000, 16'h0001, 4'b0001, 4'b0001, 0, 0));
        vecs.push_back(mk(6,  52, 0, 4'b0000, 16'h0001, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(6,  60, 0, 4'b0000, 16'h0001, 4'b0000, 4'b0000, 0, 0));

        cur_scen = -1;
        cur_cyc  = 0;
        foreach (vecs[i]) begin
            if (vecs[i].scen != cur_scen) begin
                do_reset();
                cur_scen = vecs[i].scen;
                cur_cyc  = 0;
            end
            while (cur_cyc < vecs[i].cyc) begin
                @(negedge clk);
                cur_cyc++;
            end
            act_v = int'({grant, done, busy, led});
            exp_v = int'({vecs[i].grant, vecs[i].done, vecs[i].busy, vecs[i].led});
            check($sformatf("scen%0d cyc%0d {grant,done,busy,led}", vecs[i].scen, vecs[i].cyc),
                  act_v, exp_v);
            rst    = vecs[i].rst;
            req    = vecs[i].req;
            blinks = vecs[i].blinks;
        end

        // Whole-pattern shape for requester 1 with two pulses.
        do_reset();
        req      = 4'b0010;
        blinks   = 16'h0020;
        cyc      = 0;
        led_hi   = 0;
        rises    = 0;
        done_cyc = -1;
        prev_led = 1'b0;
        while (done_cyc < 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (led) led_hi++;
            if (led && !prev_led) rises++;
            prev_led = led;
            if (done != 4'b0000) done_cyc = cyc;
        end
        req = 4'b0000;
        check("shape done cycle", done_cyc, 81);
        check("shape led-high cycles", led_hi, 40);
        check("shape pulse count", rises, 2);
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done != 4'b0000) done_cnt++;
        end
        check("shape done width", done_cnt, 0);
        check("shape grant released", int'(grant), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
